// File: rtl/mod_m_timer_bank.sv
// Bank of independent programmable mod-M counters.
// Each channel runs periodic (free-running) or one-shot, with its own enable,
// synchronous clear/start and a registered one-cycle tick at period end.
// The modulus is captured into a shadow register whenever q is 0, so a change
// to m made partway through a period only takes effect from the next period.
//
// One-shot FSM (per channel, held in run_r):
//   state | meaning
//   IDLE  | not armed; in one-shot mode the counter holds its value
//   RUN   | armed; counts while en is high, returns to IDLE on wrap or clr
// In periodic mode the FSM is held in IDLE.
module mod_m_timer_bank #(
  parameter int N_CH   = 4,
  parameter int M_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH-1:0]          mode,
  input  logic [N_CH-1:0]          start,
  input  logic [N_CH-1:0]          clr,
  input  logic [N_CH*M_BITS-1:0]   m,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          active,
  output logic [N_CH*M_BITS-1:0]   q,
  output logic                     any_tick
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [M_BITS-1:0] q_r;
    logic [M_BITS-1:0] q_nxt;
    logic [M_BITS-1:0] m_s;
    logic [M_BITS-1:0] m_live;
    logic [M_BITS-1:0] eff_m;
    logic              tick_r;
    logic              tick_nxt;
    logic              run_r;
    logic              run_nxt;
    logic              counting;
    logic              wrap;
    logic              active_c;

    assign m_live = m[i*M_BITS +: M_BITS];

    // State register: counter, shadow modulus, tick and one-shot FSM state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q_r    <= '0;
        m_s    <= '0;
        tick_r <= 1'b0;
        run_r  <= IDLE;
      end else begin
        q_r    <= q_nxt;
        tick_r <= tick_nxt;
        run_r  <= run_nxt;
        if (q_r == '0) begin
          m_s <= m_live;
        end
      end
    end

    // Next-state logic: clr beats start beats wrap beats increment.
    always_comb begin
      eff_m    = (q_r == '0) ? m_live : m_s;
      counting = en[i] & (~mode[i] | (run_r == RUN));
      wrap     = counting & (q_r == eff_m);
      q_nxt    = q_r;
      tick_nxt = 1'b0;
      run_nxt  = run_r;
      if (clr[i]) begin
        q_nxt   = '0;
        run_nxt = IDLE;
      end else if (start[i]) begin
        q_nxt   = '0;
        run_nxt = mode[i] ? RUN : IDLE;
      end else begin
        if (wrap) begin
          q_nxt    = '0;
          tick_nxt = 1'b1;
          run_nxt  = IDLE;
        end else if (counting) begin
          q_nxt = q_r + M_BITS'(1);
        end
        if (!mode[i]) begin
          run_nxt = IDLE;
        end
      end
    end

    // Output logic: one-shot reports armed state, periodic reports enable.
    always_comb begin
      active_c = mode[i] ? (run_r == RUN) : en[i];
    end

    assign q[i*M_BITS +: M_BITS] = q_r;
    assign tick[i]               = tick_r;
    assign active[i]             = active_c;
  end

  assign any_tick = |tick;

endmodule

// File: tb/tb_mod_m_timer_bank.sv
// Self-checking bench for mod_m_timer_bank: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle against
// a behavioural model of the counting rules.
module tb_mod_m_timer_bank;
  localparam int N_CH   = 4;
  localparam int M_BITS = 8;

  logic                   clk;
  logic                   reset;
  logic [N_CH-1:0]        en, mode, start, clr;
  logic [N_CH*M_BITS-1:0] m;
  logic [N_CH-1:0]        tick, active;
  logic [N_CH*M_BITS-1:0] q;
  logic                   any_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int mq[N_CH];
  int mms[N_CH];
  int mtick[N_CH];
  int mrun[N_CH];

  mod_m_timer_bank #(.N_CH(N_CH), .M_BITS(M_BITS)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .clr(clr),
    .m(m), .tick(tick), .active(active), .q(q), .any_tick(any_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qv(input int ch);
    return int'(q[ch*M_BITS +: M_BITS]);
  endfunction

  function automatic int mv(input int ch);
    return int'(m[ch*M_BITS +: M_BITS]);
  endfunction

  task automatic set_m(input int ch, input int val);
    m[ch*M_BITS +: M_BITS] = M_BITS'(val);
  endtask

  task automatic wait_q(input int ch, input int val);
    int found = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (qv(ch) == val) begin
        found = 1;
        break;
      end
    end
    check("wait_q", found, 1);
  endtask

  // Model: one step of the counting rules per edge, cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mq[i] = 0; mms[i] = 0; mtick[i] = 0; mrun[i] = 0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        int lim;
        bit cnt;
        lim = (mq[i] == 0) ? mv(i) : mms[i];
        cnt = en[i] && (!mode[i] || mrun[i] != 0);
        if (mq[i] == 0) mms[i] = mv(i);
        mtick[i] = 0;
        if (clr[i]) begin
          mq[i] = 0; mrun[i] = 0;
        end else if (start[i]) begin
          mq[i] = 0; mrun[i] = mode[i] ? 1 : 0;
        end else if (cnt && mq[i] == lim) begin
          mq[i] = 0; mtick[i] = 1; mrun[i] = 0;
        end else if (cnt) begin
          mq[i] = mq[i] + 1;
        end
        if (!mode[i]) mrun[i] = 0;
      end
    end
  end

  // Compare DUT against the model after every edge.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      logic [N_CH*M_BITS-1:0] eq;
      logic [N_CH-1:0]        et, ea;
      for (int i = 0; i < N_CH; i++) begin
        eq[i*M_BITS +: M_BITS] = M_BITS'(mq[i]);
        et[i] = (mtick[i] != 0);
        ea[i] = mode[i] ? (mrun[i] != 0) : en[i];
      end
      check("model_q", q, eq);
      check("model_tick", tick, et);
      check("model_active", active, ea);
      check("model_any_tick", any_tick, |et);
    end
  end

  initial begin
    reset = 1'b0; en = '0; mode = '0; start = '0; clr = '0; m = '0;
    set_m(0, 4); set_m(1, 2); set_m(2, 0);
    en = 4'b0111;
    #3;
    check("rst_q", q, 0);
    check("rst_tick", tick, 0);
    check("rst_any_tick", any_tick, 0);
    check("rst_active", active, 4'b0111);

    @(negedge clk); reset = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      check("per_q0", qv(0), e % 5);
      check("per_tick0", tick[0], (e % 5) == 0);
      check("per_tick1", tick[1], (e % 3) == 0);
      check("per_tick2", tick[2], 1);
      check("per_q2", qv(2), 0);
      check("per_any", any_tick, ((e % 5) == 0) || ((e % 3) == 0) || 1'b1);
    end
    // any_tick without the m==0 channel
    @(negedge clk); en[2] = 1'b0;
    @(posedge clk); #1;
    check("any_tick_or", any_tick, tick[0] | tick[1]);

    // One-shot on ch3, m=3, run twice
    for (int rep = 0; rep < 2; rep++) begin
      int nt = 0;
      @(negedge clk); mode[3] = 1'b1; set_m(3, 3); en[3] = 1'b1; start[3] = 1'b1;
      @(posedge clk); #1;
      check("os_active_start", active[3], 1);
      check("os_q_start", qv(3), 0);
      @(negedge clk); start[3] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        @(posedge clk); #1;
        check("os_tick", tick[3], j == 4);
        check("os_active", active[3], j < 4);
      end
      check("os_q_end", qv(3), 0);
      for (int j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        if (tick[3]) nt++;
      end
      check("os_no_more_ticks", nt, 0);
    end

    // Mid-period modulus change on ch0
    @(negedge clk); set_m(0, 7); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_q(0, 3);
    @(negedge clk); set_m(0, 2);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      check("mchg_q", qv(0), 3 + j);
      check("mchg_notick", tick[0], 0);
    end
    @(posedge clk); #1;
    check("mchg_wrap_q", qv(0), 0);
    check("mchg_wrap_tick", tick[0], 1);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      check("mchg_newper_tick", tick[0], (j % 3) == 0);
      check("mchg_newper_q", qv(0), j % 3);
    end

    // Enable drop holds q on ch0
    @(negedge clk); set_m(0, 5); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_q(0, 2);
    @(negedge clk); en[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("hold_q", qv(0), 2);
      check("hold_tick", tick[0], 0);
    end
    @(negedge clk); en[0] = 1'b1;
    @(posedge clk); #1;
    check("resume_q", qv(0), 3);

    // clr and start together while ch3 is running
    @(negedge clk); start[3] = 1'b1;
    @(negedge clk); start[3] = 1'b0;
    @(negedge clk); clr[3] = 1'b1; start[3] = 1'b1;
    @(posedge clk); #1;
    check("clrstart_q", qv(3), 0);
    check("clrstart_active", active[3], 0);
    check("clrstart_tick", tick[3], 0);
    @(negedge clk); clr[3] = 1'b0; start[3] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check("clrstart_idle_tick", tick[3], 0);
      check("clrstart_idle_active", active[3], 0);
    end

    // Randomized traffic, checked by the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        en[i]    = ($urandom_range(0, 7) != 0);
        start[i] = ($urandom_range(0, 15) == 0);
        clr[i]   = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 31) == 0) mode[i] = ~mode[i];
        if ($urandom_range(0, 15) == 0) set_m(i, $urandom_range(0, 9));
      end
    end

    // Asynchronous reset mid-count
    @(negedge clk);
    clr = '0; start = '0; mode = '0; en = 4'b1111;
    set_m(0, 7); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_q(0, 5);
    #3 reset = 1'b0;
    #1;
    check("async_q", q, 0);
    check("async_tick", tick, 0);
    check("async_any_tick", any_tick, 0);
    check("async_active", active, 4'b1111);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q0", qv(0), 1);
    check("post_rst_tick0", tick[0], 0);
    repeat (10) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
